fe_record_gen: RTL and testbench
================================

FE_RECORD_GEN -- requirements
Module: fe_record_gen

Interface
REQ-001 Clk  input  1  single clock, 40 MHz bunch-crossing clock; all state changes on its rising edge.
REQ-002 n_ResetIn  input  1  reset, asynchronous, active-low.
REQ-003 L1_Trig_In  input  1  level-1 trigger strobe, one clock wide per trigger.
REQ-004 ClearBC  input  1  BCR; clears the BCID counter.
REQ-005 ClearTrigId  input  1  ECR; clears the LV1ID counter.
REQ-006 HitCnt  input  4  number of emulated hit records generated per trigger (0-15).
REQ-007 Read_Fifo  input  1  pop strobe from the downstream output serializer.
REQ-008 Data_Word  output  24  head-of-FIFO record, first-word-fall-through.
REQ-009 Empty  output  1  high when the record FIFO holds no words.
REQ-010 Skipped  output  8  saturating count of triggers dropped on trigger-queue overflow.

Function
REQ-011 BCID counter: 10 bit, +1 every Clk, wraps 1023->0; ClearBC high loads 0 at the next edge.
REQ-012 LV1ID counter: 5 bit, +1 per accepted trigger, wraps 31->0; ClearTrigId wins over increment.
REQ-013 Trigger queue: 4 entries of {LV1ID,BCID}; on L1_Trig_In the values held before the edge are pushed, including a trigger coincident with ClearBC or ClearTrigId.
REQ-014 Trigger with queue full: the trigger is dropped, LV1ID is not incremented, and Skipped increments; Skipped saturates at 255.
REQ-015 Record FIFO: 16 x 24 bit; a write occurs only when occupancy < 16, with no bypass on a simultaneous read at full.
REQ-016 FSM states: IDLE, HEADER, HITS.
  - IDLE -> HEADER when the trigger queue is non-empty.
  - HEADER -> HITS or IDLE after the DH write.
  - HITS -> IDLE after the last hit write.
REQ-017 HEADER: pop the queue entry; write DH = {8'hE9, 1'b0, LV1ID[4:0], BCID[9:0]}; latch HitCnt into the hit counter; go to IDLE if the latched HitCnt = 0.
REQ-018 HITS: record k (k = 0..HitCnt-1) = {col=7'(k+1), row=9'(k+1), ToT1=4'(k), ToT2=4'hF}; one record per clock.
REQ-019 Any FSM write that finds the FIFO full stalls the FSM in its state, with no data lost and no duplication.
REQ-020 Latency: with the FIFO empty and the FSM in IDLE, the trigger sampled at edge t gives a DH written at edge t+2; Empty falls after edge t+2.
REQ-021 Read_Fifo with Empty=0 pops one word at the edge; Read_Fifo with Empty=1 is ignored.
REQ-022 Data_Word = 24'h000000 whenever Empty=1.
REQ-023 A simultaneous read and write at occupancy 1..15 leaves occupancy unchanged and preserves order.
REQ-024 Records leave the FIFO in strict generation order; every DH is followed by exactly its HitCnt hit records.

Reset
REQ-025 n_ResetIn low immediately forces the following, independent of Clk:
  - BCID = 0, LV1ID = 0, Skipped = 0;
  - trigger queue and record FIFO empty;
  - FSM to IDLE;
  - Empty = 1, Data_Word = 0.
REQ-026 Reset asserted mid-event discards the partial event; after release, the first trigger produces a DH with LV1ID = 0.
REQ-027 Reset release is synchronous-safe: the first state change occurs at the first Clk edge after deassertion.

Configuration
REQ-028 FE_RECORD_GEN_SR_EN defined: after one or more triggers are dropped, a service record {8'hEF, 6'd14, 10'(number dropped since the last SR)} is written before the next DH. The drop counter since the last SR saturates at 1023 and clears when the SR is written.
REQ-029 FE_RECORD_GEN_SR_EN undefined: dropped triggers produce no record; only Skipped reports them.

Verification
REQ-030 Reset, HitCnt=0, one trigger at BCID 37 -> one word 24'hE90025, then Empty=1; Skipped=0.
REQ-031 HitCnt=3, one trigger, Read_Fifo held high -> the following words in order, then Empty:
  - DH;
  - {7'd1, 9'd1, 4'h0, 4'hF};
  - {7'd2, 9'd2, 4'h1, 4'hF};
  - {7'd3, 9'd3, 4'h2, 4'hF}.
REQ-032 Read_Fifo held low, HitCnt=15, two triggers -> the FSM stalls at FIFO occupancy 16. Then pop continuously -> 32 words total with no loss, LV1ID fields 0 then 1.
REQ-033 Read_Fifo low, 6 triggers on consecutive clocks, HitCnt=15 -> Skipped = 1 after the burst, which is the sixth trigger; the first DH pops, freeing a queue slot before the sixth trigger, so only the sixth is dropped. With FE_RECORD_GEN_SR_EN, word 24'hEF3801 precedes the next DH after the drop.
REQ-034 Trigger coincident with ClearTrigId at LV1ID 5 -> DH carries LV1ID 5, and the next trigger carries LV1ID 0. n_ResetIn pulsed mid-HITS -> Empty=1 immediately.

Source files
------------

// File: rtl/fe_record_gen.sv
`timescale 1ns/1ps
// Front-end record generator: stamps L1 triggers with {LV1ID,BCID}, queues them, and emits
// a data header plus HitCnt emulated hit records per trigger into a 16-deep FWFT FIFO.
// Optional feature macro: FE_RECORD_GEN_SR_EN (service record reporting dropped triggers).
module fe_record_gen (
    input  logic        Clk,
    input  logic        n_ResetIn,
    input  logic        L1_Trig_In,
    input  logic        ClearBC,
    input  logic        ClearTrigId,
    input  logic [3:0]  HitCnt,
    input  logic        Read_Fifo,
    output logic [23:0] Data_Word,
    output logic        Empty,
    output logic [7:0]  Skipped,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_HITS   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_bcid;
    logic [4:0]  r_lv1id;
    logic [7:0]  r_skipped;

    logic [14:0] r_tq [4];
    logic [1:0]  r_tq_wp;
    logic [1:0]  r_tq_rp;
    logic [2:0]  r_tq_cnt;

    logic [23:0] r_fifo [16];
    logic [3:0]  r_wp;
    logic [3:0]  r_rp;
    logic [4:0]  r_cnt;

    logic [3:0]  r_hit_max;
    logic [3:0]  r_hit_idx;

    logic        w_tq_full;
    logic        w_tq_empty;
    logic        w_trig_acc;
    logic        w_trig_drop;
    logic [14:0] w_tq_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_rd;
    logic        w_wr;
    logic [23:0] w_wdata;
    logic        w_tq_pop;
    logic        w_hit_load;
    logic        w_hit_inc;
    logic [3:0]  w_k1;

`ifdef FE_RECORD_GEN_SR_EN
    logic [9:0]  r_sr_cnt;
    logic        r_sr_done;
    logic        w_sr_wr;
`endif

    assign w_tq_full    = (r_tq_cnt == 3'd4);
    assign w_tq_empty   = (r_tq_cnt == 3'd0);
    assign w_trig_acc   = L1_Trig_In && !w_tq_full;
    assign w_trig_drop  = L1_Trig_In && w_tq_full;
    assign w_tq_head    = r_tq[r_tq_rp];
    assign w_fifo_full  = (r_cnt == 5'd16);
    assign w_fifo_empty = (r_cnt == 5'd0);
    assign w_k1         = r_hit_idx + 4'd1;

    // Downstream handshake: Empty=0 means Data_Word is valid; Read_Fifo acts as ready and a
    // word is consumed only on an edge where both are true. Reads while Empty=1 are ignored.
    assign w_rd        = Read_Fifo && !w_fifo_empty;
    assign Data_Word   = w_fifo_empty ? 24'h000000 : r_fifo[r_rp];
    assign Empty       = w_fifo_empty;
    assign Skipped     = r_skipped;
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wdata     = 24'h000000;
        w_tq_pop    = 1'b0;
        w_hit_load  = 1'b0;
        w_hit_inc   = 1'b0;
`ifdef FE_RECORD_GEN_SR_EN
        w_sr_wr     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_tq_empty) w_state_nxt = S_HEADER;
            end
            S_HEADER: begin
                // A full FIFO holds the FSM here; nothing is popped until the write lands.
                if (!w_fifo_full) begin
`ifdef FE_RECORD_GEN_SR_EN
                    if ((r_sr_cnt != 10'd0) && !r_sr_done) begin
                        w_wr    = 1'b1;
                        w_wdata = {8'hEF, 6'd14, r_sr_cnt};
                        w_sr_wr = 1'b1;
                    end else
`endif
                    begin
                        w_wr       = 1'b1;
                        w_wdata    = {8'hE9, 1'b0, w_tq_head[14:10], w_tq_head[9:0]};
                        w_tq_pop   = 1'b1;
                        w_hit_load = 1'b1;
                        w_state_nxt = (HitCnt == 4'd0) ? S_IDLE : S_HITS;
                    end
                end
            end
            S_HITS: begin
                if (!w_fifo_full) begin
                    w_wr    = 1'b1;
                    w_wdata = {3'b000, w_k1, 5'b00000, w_k1, r_hit_idx, 4'hF};
                    if (r_hit_idx == r_hit_max - 4'd1) w_state_nxt = S_IDLE;
                    else                                w_hit_inc   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge n_ResetIn) begin
        if (!n_ResetIn) begin
            r_state   <= S_IDLE;
            r_bcid    <= 10'd0;
            r_lv1id   <= 5'd0;
            r_skipped <= 8'd0;
            r_tq_wp   <= 2'd0;
            r_tq_rp   <= 2'd0;
            r_tq_cnt  <= 3'd0;
            r_wp      <= 4'd0;
            r_rp      <= 4'd0;
            r_cnt     <= 5'd0;
            r_hit_max <= 4'd0;
            r_hit_idx <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bcid  <= ClearBC ? 10'd0 : r_bcid + 10'd1;

            if (ClearTrigId)     r_lv1id <= 5'd0;
            else if (w_trig_acc) r_lv1id <= r_lv1id + 5'd1;

            if (w_trig_drop && (r_skipped != 8'hFF)) r_skipped <= r_skipped + 8'd1;

            if (w_trig_acc) r_tq_wp <= r_tq_wp + 2'd1;
            if (w_tq_pop)   r_tq_rp <= r_tq_rp + 2'd1;
            r_tq_cnt <= r_tq_cnt + {2'b00, w_trig_acc} - {2'b00, w_tq_pop};

            if (w_wr) r_wp <= r_wp + 4'd1;
            if (w_rd) r_rp <= r_rp + 4'd1;
            r_cnt <= r_cnt + {4'b0000, w_wr} - {4'b0000, w_rd};

            if (w_hit_load) begin
                r_hit_max <= HitCnt;
                r_hit_idx <= 4'd0;
            end else if (w_hit_inc) begin
                r_hit_idx <= r_hit_idx + 4'd1;
            end
        end
    end

`ifdef FE_RECORD_GEN_SR_EN
    // The done flag forces a DH between consecutive service records so that a steady
    // drop stream cannot starve the header path.
    always_ff @(posedge Clk or negedge n_ResetIn) begin
        if (!n_ResetIn) begin
            r_sr_cnt  <= 10'd0;
            r_sr_done <= 1'b0;
        end else begin
            if (w_sr_wr)                                r_sr_cnt <= {9'd0, w_trig_drop};
            else if (w_trig_drop && (r_sr_cnt != 10'h3FF)) r_sr_cnt <= r_sr_cnt + 10'd1;

            if (w_sr_wr)       r_sr_done <= 1'b1;
            else if (w_tq_pop) r_sr_done <= 1'b0;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (w_trig_acc) r_tq[r_tq_wp] <= {r_lv1id, r_bcid};
        if (w_wr)       r_fifo[r_wp]  <= w_wdata;
    end

endmodule

// File: tb/tb_fe_record_gen.sv
`timescale 1ns/1ps
// Bench for fe_record_gen: table-driven single-trigger vectors, directed multi-cycle
// sequences and a randomized run, all scored against an expected word queue.
module tb_fe_record_gen;

    logic        Clk = 1'b0;
    logic        n_ResetIn;
    logic        L1_Trig_In;
    logic        ClearBC;
    logic        ClearTrigId;
    logic [3:0]  HitCnt;
    logic        Read_Fifo;
    logic [23:0] Data_Word;
    logic        Empty;
    logic [7:0]  Skipped;
    logic [1:0]  o_dbg_state;

    fe_record_gen dut (
        .Clk         (Clk),
        .n_ResetIn   (n_ResetIn),
        .L1_Trig_In  (L1_Trig_In),
        .ClearBC     (ClearBC),
        .ClearTrigId (ClearTrigId),
        .HitCnt      (HitCnt),
        .Read_Fifo   (Read_Fifo),
        .Data_Word   (Data_Word),
        .Empty       (Empty),
        .Skipped     (Skipped),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #12 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #(24 * 60000);
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model / scoreboard ----------------
    logic [23:0] exp_q[$];
    int m_bcid, m_lv1id, m_skipped, m_sr_cnt, n_popped;

    function automatic logic [23:0] dh_word(input int lv1, input int bc);
        return {8'hE9, 1'b0, 5'(lv1), 10'(bc)};
    endfunction

    function automatic logic [23:0] hit_word(input int k);
        return {7'(k + 1), 9'(k + 1), 4'(k), 4'hF};
    endfunction

    function automatic int dh_count();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][23:16] == 8'hE9) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge: drives inputs for the next posedge, scores a pop, updates the model.
    task automatic cycle(input logic trig, input logic clr_bc, input logic clr_id,
                         input logic rd, input logic acc);
        L1_Trig_In  = trig;
        ClearBC     = clr_bc;
        ClearTrigId = clr_id;
        Read_Fifo   = rd;
        if (Empty) check("data_when_empty", Data_Word, 0);
        if (rd && !Empty) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h expected no word", Data_Word);
            end else begin
                check("pop_word", Data_Word, exp_q.pop_front());
            end
            n_popped++;
        end
        if (trig) begin
            if (acc) begin
                exp_q.push_back(dh_word(m_lv1id, m_bcid));
                for (int k = 0; k < int'(HitCnt); k++) exp_q.push_back(hit_word(k));
            end else begin
                if (m_skipped < 255)  m_skipped++;
                if (m_sr_cnt  < 1023) m_sr_cnt++;
            end
        end
        @(posedge Clk);
        m_bcid = clr_bc ? 0 : (m_bcid + 1) % 1024;
        if (clr_id)            m_lv1id = 0;
        else if (trig && acc)  m_lv1id = (m_lv1id + 1) % 32;
        @(negedge Clk);
    endtask

    task automatic idle(input int n, input logic rd);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, rd, 1'b1);
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while ((exp_q.size() > 0 || !Empty) && b < budget) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            b++;
        end
        check("drain_remaining", exp_q.size(), 0);
        check("empty_after_drain", Empty, 1);
    endtask

    task automatic do_reset();
        n_ResetIn   = 1'b0;
        L1_Trig_In  = 1'b0;
        ClearBC     = 1'b0;
        ClearTrigId = 1'b0;
        Read_Fifo   = 1'b0;
        #1;
        check("rst_empty", Empty, 1);
        check("rst_data", Data_Word, 0);
        check("rst_skipped", Skipped, 0);
        check("rst_state", o_dbg_state, 0);
        exp_q.delete();
        m_bcid = 0; m_lv1id = 0; m_skipped = 0; m_sr_cnt = 0;
        @(negedge Clk);
        @(negedge Clk);
        n_ResetIn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [3:0]  hit;
        int          bcid;
        logic [23:0] exp_dh;
        int          exp_n;
    } vec_t;

    vec_t vecs[5];

    initial begin
        n_ResetIn = 1'b0; L1_Trig_In = 1'b0; ClearBC = 1'b0; ClearTrigId = 1'b0;
        Read_Fifo = 1'b0; HitCnt = 4'd0;

        vecs[0] = '{4'd0,  37,   24'hE90025, 1};
        vecs[1] = '{4'd3,  5,    24'hE90005, 4};
        vecs[2] = '{4'd15, 1023, 24'hE903FF, 16};
        vecs[3] = '{4'd1,  0,    24'hE90000, 2};
        vecs[4] = '{4'd7,  512,  24'hE90200, 8};

        @(negedge Clk);

        // Single triggers: latency, DH contents, record count.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            HitCnt = vecs[v].hit;
            while (m_bcid != vecs[v].bcid) idle(1, 1'b0);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            check("lat_t0_empty", Empty, 1);
            idle(1, 1'b0);
            check("lat_t1_empty", Empty, 1);
            idle(1, 1'b0);
            check("lat_t2_empty", Empty, 0);
            check("vec_dh", Data_Word, vecs[v].exp_dh);
            n_popped = 0;
            drain(100);
            check("vec_nwords", n_popped, vecs[v].exp_n);
            check("vec_skipped", Skipped, 0);
        end

        // HitCnt=3 with Read_Fifo held high throughout.
        do_reset();
        HitCnt = 4'd3;
        n_popped = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain(40);
        check("rd_high_nwords", n_popped, 4);

        // Two 16-word events with reads off: FSM parks in HEADER behind a full FIFO.
        do_reset();
        HitCnt = 4'd15;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(40, 1'b0);
        check("stall_state", o_dbg_state, 1);
        check("stall_head", Data_Word, 24'hE90000);
        n_popped = 0;
        drain(200);
        check("stall_nwords", n_popped, 32);

        // Six back-to-back triggers: only the sixth is dropped.
        do_reset();
        HitCnt = 4'd15;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, (i < 5));
        idle(30, 1'b0);
        check("burst_skipped", Skipped, 1);
`ifdef FE_RECORD_GEN_SR_EN
        exp_q.insert(16, 24'hEF3801);
`endif
        drain(300);
        check("burst_skipped_after", Skipped, m_skipped);

        // Long drop stream: Skipped saturates.
        do_reset();
        HitCnt = 4'd15;
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, (i < 5));
        check("skipped_sat", Skipped, 255);
        check("skipped_model", Skipped, m_skipped);
`ifdef FE_RECORD_GEN_SR_EN
        exp_q.insert(16, {8'hEF, 6'd14, 10'(m_sr_cnt)});
`endif
        drain(400);

        // ECR and BCR coincident with triggers.
        do_reset();
        HitCnt = 4'd0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            idle(4, 1'b1);
        end
        drain(20);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b0);
        check("ecr_trig_lv1", Data_Word[14:10], 5);
        drain(20);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        check("post_ecr_lv1", Data_Word[14:10], 0);
        drain(20);
        HitCnt = 4'd2;
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain(40);

        // Reset asserted mid-HITS, off the clock edge.
        do_reset();
        HitCnt = 4'd15;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8, 1'b0);
        check("mid_hits_state", o_dbg_state, 2);
        #3;
        do_reset();
        HitCnt = 4'd2;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        check("post_reset_dh", Data_Word, 24'hE90000);
        drain(40);

        // Randomized traffic, no overflow; HitCnt changes only between drained segments.
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            HitCnt = 4'($urandom_range(0, 15));
            for (int c = 0; c < 250; c++) begin
                logic t, r, cb, ci;
                t  = ($urandom_range(0, 9) == 0) && (dh_count() <= 3);
                r  = ($urandom_range(0, 3) < ((seg % 3) + 1));
                cb = ($urandom_range(0, 199) == 0);
                ci = ($urandom_range(0, 99) == 0);
                cycle(t, cb, ci, r, 1'b1);
            end
            drain(600);
        end
        check("rand_skipped", Skipped, m_skipped);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
